// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - stopwatch control bundle; AUTO_STOP_EN adds the ovf flag
interface stopwatch_ctrl_if;
    logic       x;
    logic       lap_n;
    logic       pre;
    logic       pre1;
`ifdef AUTO_STOP_EN
    logic       ovf;
`endif
    logic       tick;
    logic       cnt_en;
    logic       cnt_clr;
    logic       load;
    logic       load_sel;
    logic       hold;
    logic [1:0] state;

    modport master (
`ifdef AUTO_STOP_EN
        output ovf,
`endif
        output x, lap_n, pre, pre1,
        input  tick, cnt_en, cnt_clr, load, load_sel, hold, state
    );

    modport slave (
`ifdef AUTO_STOP_EN
        input  ovf,
`endif
        input  x, lap_n, pre, pre1,
        output tick, cnt_en, cnt_clr, load, load_sel, hold, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/stop/lap sequencer with tick prescaler and input conditioning
// Optional overflow auto-stop enabled by defining AUTO_STOP_EN.
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic              clock,
    input logic              reset,
    stopwatch_ctrl_if.slave  bus
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10,
        S_LAP  = 2'b11
    } state_t;

    state_t         state;
    logic [PW-1:0]  presc;
    logic [DW-1:0]  db_cnt;
    logic           x_s1, x_s2, x_db;
    logic           lap_s1, lap_s2, lap_d;
    logic           pre_s1, pre_s2, pre_d;
    logic           pre1_s1, pre1_s2, pre1_d;
    logic           cnt_en_q, cnt_clr_q, load_q, load_sel_q, hold_q;
    logic           lap_ev, pre_ev, pre1_ev;
    logic           counting, tick_due;
`ifdef AUTO_STOP_EN
    logic           ovf_lock;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_s1    <= 1'b1;
            x_s2    <= 1'b1;
            lap_s1  <= 1'b1;
            lap_s2  <= 1'b1;
            lap_d   <= 1'b1;
            pre_s1  <= 1'b0;
            pre_s2  <= 1'b0;
            pre_d   <= 1'b0;
            pre1_s1 <= 1'b0;
            pre1_s2 <= 1'b0;
            pre1_d  <= 1'b0;
        end else begin
            x_s1    <= bus.x;
            x_s2    <= x_s1;
            lap_s1  <= bus.lap_n;
            lap_s2  <= lap_s1;
            lap_d   <= lap_s2;
            pre_s1  <= bus.pre;
            pre_s2  <= pre_s1;
            pre_d   <= pre_s2;
            pre1_s1 <= bus.pre1;
            pre1_s2 <= pre1_s1;
            pre1_d  <= pre1_s2;
        end
    end

    assign lap_ev  = lap_d & ~lap_s2;
    assign pre_ev  = pre_s2 & ~pre_d;
    assign pre1_ev = pre1_s2 & ~pre1_d;

    // Any sample matching x_db restarts the stability window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            x_db   <= 1'b1;
        end else if (x_s2 == x_db) begin
            db_cnt <= '0;
        end else if (db_cnt + 1'b1 == DW'(DEBOUNCE_CYCLES)) begin
            db_cnt <= '0;
            x_db   <= x_s2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign counting = (state == S_RUN) || (state == S_LAP);
    assign tick_due = counting && (presc == PW'(TICK_DIV - 1));
`ifdef AUTO_STOP_EN
    assign bus.tick = tick_due & ~bus.ovf;
`else
    assign bus.tick = tick_due;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            presc      <= '0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            load_q     <= 1'b0;
            load_sel_q <= 1'b0;
            hold_q     <= 1'b0;
`ifdef AUTO_STOP_EN
            ovf_lock   <= 1'b0;
`endif
        end else begin
            cnt_clr_q <= 1'b0;
            load_q    <= 1'b0;
            if (counting)
                presc <= tick_due ? '0 : presc + 1'b1;
`ifdef AUTO_STOP_EN
            if (x_db)
                ovf_lock <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!x_db) begin
                        state    <= S_RUN;
                        cnt_en_q <= 1'b1;
                    end else if (pre_ev) begin
                        load_q     <= 1'b1;
                        load_sel_q <= 1'b0;
                    end else if (pre1_ev) begin
                        load_q     <= 1'b1;
                        load_sel_q <= 1'b1;
                    end
                end
                S_RUN, S_LAP: begin
`ifdef AUTO_STOP_EN
                    if (tick_due && bus.ovf) begin
                        state    <= S_STOP;
                        cnt_en_q <= 1'b0;
                        hold_q   <= 1'b0;
                        ovf_lock <= 1'b1;
                    end else
`endif
                    if (x_db) begin
                        state    <= S_STOP;
                        cnt_en_q <= 1'b0;
                        hold_q   <= 1'b0;
                    end else if (lap_ev) begin
                        state  <= (state == S_RUN) ? S_LAP : S_RUN;
                        hold_q <= (state == S_RUN);
                    end
                end
                default: begin
                    // STOP: priority is run input, then lap clear, then preset A, then B.
`ifdef AUTO_STOP_EN
                    if (!x_db && !ovf_lock) begin
`else
                    if (!x_db) begin
`endif
                        state    <= S_RUN;
                        cnt_en_q <= 1'b1;
                    end else if (lap_ev) begin
                        state     <= S_IDLE;
                        presc     <= '0;
                        cnt_clr_q <= 1'b1;
                    end else if (pre_ev || pre1_ev) begin
                        state      <= S_IDLE;
                        presc      <= '0;
                        load_q     <= 1'b1;
                        load_sel_q <= ~pre_ev;
                    end
                end
            endcase
        end
    end

    assign bus.cnt_en   = cnt_en_q;
    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.load     = load_q;
    assign bus.load_sel = load_sel_q;
    assign bus.hold     = hold_q;
    assign bus.state    = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   ticks;
    int   first_tick;
    int   last_tick;
    bit   found;

    stopwatch_ctrl_if sif ();

    stopwatch_ctrl #(
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(sif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // {state[1:0], tick, cnt_en, cnt_clr, load, load_sel, hold}
    function automatic logic [7:0] outs();
        return {sif.state, sif.tick, sif.cnt_en, sif.cnt_clr, sif.load, sif.load_sel, sif.hold};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        sif.x = 1'b1; sif.lap_n = 1'b1; sif.pre = 1'b0; sif.pre1 = 1'b0;
        @(negedge clock);

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            sif.x     = 1'($urandom_range(0, 1));
            sif.lap_n = 1'($urandom_range(0, 1));
            sif.pre   = 1'($urandom_range(0, 1));
            sif.pre1  = 1'($urandom_range(0, 1));
            step();
            chk("reset_hold", outs(), 8'h00);
        end
        sif.x = 1'b1; sif.lap_n = 1'b1; sif.pre = 1'b0; sif.pre1 = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_after_release", outs(), 8'h00);
        end

        // Three-cycle x glitch must be discarded
        sif.x = 1'b0;
        step(); step(); step();
        sif.x = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch_idle", outs(), 8'h00);
        end

        // Presets in IDLE
        sif.pre = 1'b1;
        step(); step();
        chk("pre_before_load", outs(), 8'h00);
        step();
        chk("pre_load_a", outs(), 8'h04);
        step();
        chk("pre_load_once", outs(), 8'h00);
        sif.pre = 1'b0;
        step(); step(); step();
        sif.pre1 = 1'b1;
        step(); step(); step();
        chk("pre1_load_b", outs(), 8'h06);
        step();
        chk("pre1_sel_holds", outs(), 8'h02);
        sif.pre1 = 1'b0;
        step(); step(); step();
        sif.pre = 1'b1; sif.pre1 = 1'b1;
        step(); step(); step();
        chk("both_load_a", outs(), 8'h04);
        step();
        chk("both_single_load", outs(), 8'h00);
        sif.pre = 1'b0; sif.pre1 = 1'b0;
        step(); step(); step();

        // Run entry latency: 2 sync + 4 debounce + 1 state
        sif.x = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("run_not_yet", outs(), 8'h00);
        step();
        chk("run_entry", outs(), 8'h50);

        // 100 cycles -> 10 ticks at 10-cycle spacing, first at cycle 10 of RUN
        ticks = 0; first_tick = 0; last_tick = 0;
        sif.pre = 1'b1;
        for (int c = 2; c <= 101; c++) begin
            step();
            if (sif.load !== 1'b0) chk("no_load_in_run", {7'd0, sif.load}, 8'h00);
            if (sif.tick === 1'b1) begin
                if (ticks == 0) first_tick = c;
                else chk("tick_spacing", 8'(c - last_tick), 8'd10);
                last_tick = c;
                ticks++;
            end
        end
        sif.pre = 1'b0;
        chk("tick_count", 8'(ticks), 8'd10);
        chk("first_tick_cycle", 8'(first_tick), 8'd10);

        // Lap in RUN
        sif.lap_n = 1'b0;
        step(); step();
        sif.lap_n = 1'b1;
        step();
        chk("lap_enter", outs(), 8'hD1);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sif.tick === 1'b1) ticks++;
        end
        chk("lap_ticks", 8'(ticks), 8'd1);
        sif.lap_n = 1'b0;
        step(); step();
        sif.lap_n = 1'b1;
        step();
        chk("lap_exit", outs(), 8'h50);

        // Stop with prescaler at 5
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (sif.tick === 1'b1) found = 1'b1;
        end
        chk("tick_found", {7'd0, found}, 8'h01);
        for (int i = 0; i < 9; i++) step();
        sif.x = 1'b1;
        step();
        chk("tick_during_debounce", outs(), 8'h70);
        for (int i = 0; i < 5; i++) step();
        chk("stop_not_yet", outs(), 8'h50);
        step();
        chk("stop_entry", outs(), 8'h80);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sif.tick === 1'b1) ticks++;
        end
        chk("stop_no_ticks", 8'(ticks), 8'd0);

        // Resume keeps fractional period
        sif.x = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("resume_not_yet", outs(), 8'h80);
        step();
        chk("resume_entry", outs(), 8'h50);
        step(); step(); step();
        chk("resume_no_early_tick", outs(), 8'h50);
        step();
        chk("resume_first_tick", outs(), 8'h70);

        // STOP then lap clears to IDLE
        sif.x = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("stop_again", outs(), 8'h80);
        sif.lap_n = 1'b0;
        step(); step();
        sif.lap_n = 1'b1;
        step();
        chk("clr_strobe", outs(), 8'h08);
        step();
        chk("clr_single", outs(), 8'h00);

        // Asynchronous reset mid-RUN
        sif.x = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("run_again", outs(), 8'h50);
        step(); step(); step();
        #2 reset = 1'b0;
        #1 chk("async_reset", outs(), 8'h00);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_debounce", outs(), 8'h00);
        end
        step();
        chk("post_reset_run", outs(), 8'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
